// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-loader state encoding.
package cpu_pkg;
  localparam int ADDR_W = 10;
  localparam int WORD_W = 18;
  localparam int DEPTH  = 1024;

  // DEPTH at word-count width, so length checks compare equal widths.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;
endpackage

// File: rtl/loader_byte_packer.sv
// Assembles three big-endian bytes into one instruction word; word_ready pulses the cycle after byte 2.
// Accepts a byte whenever byte_vld is high; the caller owns backpressure.
module loader_byte_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  output logic              last_byte,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);
  logic [1:0] idx;

  assign last_byte = (idx == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= 2'd0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        idx <= 2'd0;
      end else if (byte_vld) begin
        case (idx)
          2'd0:    word[WORD_W-1:16] <= byte_dat[1:0];
          2'd1:    word[15:8]        <= byte_dat;
          default: begin
            word[7:0]  <= byte_dat;
            word_ready <= 1'b1;
          end
        endcase
        idx <= last_byte ? 2'd0 : idx + 2'd1;
      end
    end
  end
endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the CPU in reset until it is complete.
// imem_we one cycle after a word's third byte; in_ready only in HEADER/LOAD/CHECK; LOADER_CHECKSUM_EN adds a trailing XOR byte.
module instr_loader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);
  localparam int HI_W = ADDR_W + 1 - 8;

  loader_state_t   state, state_nxt, after_last;
  logic            hdr_idx;
  logic [HI_W-1:0] len_hi;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] hdr_len;
  logic            accept, load_start, last_byte, finish_write;

  assign in_ready     = (state == HEADER) || (state == LOAD) || (state == CHECK);
  assign accept       = in_valid && in_ready;
  assign hdr_len      = {len_hi, in_data};
  assign load_start   = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign finish_write = (word_count + 1'b1) == len;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign after_last = CHECK;
`else
  assign after_last = DONE;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = HEADER;
      HEADER: if (accept && hdr_idx)
                state_nxt = ((hdr_len == '0) || (hdr_len > DEPTH_CNT)) ? ERROR : LOAD;
      LOAD:   if (accept && last_byte) state_nxt = WRITE;
      WRITE:  state_nxt = finish_write ? after_last : LOAD;
`ifdef LOADER_CHECKSUM_EN
      CHECK:  if (accept) state_nxt = (in_data == csum) ? DONE : ERROR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from next-state so they change on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == HEADER) || (state_nxt == LOAD) ||
                   (state_nxt == WRITE)  || (state_nxt == CHECK);
      done      <= (state_nxt == DONE);
      error     <= (state_nxt == ERROR);
      cpu_reset <= (state_nxt != DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_idx    <= 1'b0;
      len_hi     <= '0;
      len        <= '0;
      imem_addr  <= '0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else if (load_start) begin
      hdr_idx    <= 1'b0;
      len_hi     <= '0;
      len        <= '0;
      imem_addr  <= '0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      if (state == HEADER && accept) begin
        hdr_idx <= 1'b1;
        if (!hdr_idx) len_hi <= in_data[HI_W-1:0];
        else          len    <= hdr_len;
      end
`ifdef LOADER_CHECKSUM_EN
      if (state == LOAD && accept) csum <= csum ^ in_data;
`endif
      if (state == WRITE) begin
        imem_addr  <= imem_addr + 1'b1;
        word_count <= word_count + 1'b1;
      end
    end
  end

  loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_start),
    .byte_vld  (accept && (state == LOAD)),
    .byte_dat  (in_data),
    .last_byte (last_byte),
    .word_ready(imem_we),
    .word      (imem_wdata)
  );
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: image model in queues, per-cycle write/status checker, literal pins.
module tb_instr_loader;
  import cpu_pkg::*;

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, imem_we, cpu_reset, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic [ADDR_W:0]   word_count;

  instr_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  wr_t         exp_q[$];
  wr_t         exp_w;
  byte_t       stim[$];
  logic [WORD_W-1:0] mem [0:DEPTH-1];
  int          start_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle checker: every write must be the next one the model predicted.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) begin
        mem[imem_addr] = imem_wdata;
        wr_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr, imem_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(exp_w.a));
          chk("wr_data", 32'(imem_wdata), 32'(exp_w.d));
        end
      end
      chk("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
      chk("in_ready_implies_busy", 32'(in_ready && !busy), 32'(0));
    end
  end

  // Image model: decode header, predict writes, decide success.
  task automatic model(output bit ok, output int n);
    int    len;
    byte_t x, b0;
    wr_t   e;
    len = (int'(stim[0] & 8'h07) << 8) | int'(stim[1]);
    n  = 0;
    ok = 1'b0;
    if (len == 0 || len > DEPTH) return;
    x = 8'h00;
    for (int w = 0; w < len; w++) begin
      b0  = stim[2 + 3*w];
      e.a = ADDR_W'(w);
      e.d = {b0[1:0], stim[3 + 3*w], stim[4 + 3*w]};
      x   = x ^ stim[2 + 3*w] ^ stim[3 + 3*w] ^ stim[4 + 3*w];
      exp_q.push_back(e);
      n++;
    end
`ifdef LOADER_CHECKSUM_EN
    ok = (stim[2 + 3*len] == x);
`else
    ok = 1'b1;
`endif
  endtask

  task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
    byte_t x;
    x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
    stim.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends the first cnt bytes of stim; gap inserts an idle cycle before each byte.
  task automatic send(input int cnt, input bit gap);
    int budget;
    for (int i = 0; i < cnt; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        if (i == start_at) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = stim[i];
      budget   = 0;
      while (!in_ready && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: byte %0d never accepted, expected acceptance", i);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic finish_check(input string name, input bit ok, input int n);
    int budget;
    budget = 0;
    while (!(done || error) && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    chk({name, "_done"},       32'(done),       32'(ok));
    chk({name, "_error"},      32'(error),      32'(!ok));
    chk({name, "_cpu_reset"},  32'(cpu_reset),  32'(!ok));
    chk({name, "_busy"},       32'(busy),       32'(0));
    chk({name, "_word_count"}, 32'(word_count), 32'(n));
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_in_ready"},   32'(in_ready),   32'(0));
    chk({name, "_imem_we"},    32'(imem_we),    32'(0));
    chk({name, "_imem_addr"},  32'(imem_addr),  32'(0));
    chk({name, "_imem_wdata"}, 32'(imem_wdata), 32'(0));
    chk({name, "_cpu_reset"},  32'(cpu_reset),  32'(1));
    chk({name, "_busy"},       32'(busy),       32'(0));
    chk({name, "_done"},       32'(done),       32'(0));
    chk({name, "_error"},      32'(error),      32'(0));
    chk({name, "_word_count"}, 32'(word_count), 32'(0));
  endtask

  bit ok;
  int n, w0;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_values("idle");
    chk("idle_no_writes", 32'(wr_seen), 32'(0));

    // Basic two-word image.
    stim = {8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h03);
`endif
    model(ok, n);
    chk("model_basic_ok", 32'(ok), 32'(1));
    pulse_start();
    send(stim.size(), 1'b0);
    finish_check("basic", ok, n);
    chk("basic_mem0", 32'(mem[0]), 32'h12345);
    chk("basic_mem1", 32'(mem[1]), 32'h2ABCD);
    chk("basic_word_count_lit", 32'(word_count), 32'd2);

    // Zero-length and over-length headers.
    w0 = wr_seen;
    stim = {8'h00, 8'h00};
    model(ok, n);
    pulse_start();
    send(2, 1'b0);
    finish_check("len_zero", ok, n);
    chk("len_zero_error_lit", 32'(error), 32'd1);
    stim = {8'h04, 8'h01};
    model(ok, n);
    pulse_start();
    send(2, 1'b0);
    finish_check("len_1025", ok, n);
    chk("len_1025_error_lit", 32'(error), 32'd1);
    chk("bad_hdr_no_writes", 32'(wr_seen), 32'(w0));

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: the word still lands, then the load fails.
    stim = {8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    model(ok, n);
    pulse_start();
    send(stim.size(), 1'b0);
    finish_check("bad_csum", ok, n);
    chk("bad_csum_error_lit", 32'(error), 32'd1);
    chk("bad_csum_mem0", 32'(mem[0]), 32'h00001);
`endif

    // Three words with in_valid toggling and a start pulse mid-load.
    stim = {8'h00, 8'h03, 8'hFF, 8'h00, 8'h11, 8'h00, 8'hAA, 8'h55, 8'h7E, 8'h12, 8'h34};
    add_csum();
    model(ok, n);
    pulse_start();
    start_at = 4;
    send(stim.size(), 1'b1);
    start_at = -1;
    finish_check("gapped", ok, n);
    chk("gapped_mem0", 32'(mem[0]), 32'h30011);
    chk("gapped_mem1", 32'(mem[1]), 32'h0AA55);
    chk("gapped_mem2", 32'(mem[2]), 32'h21234);

    // Reset after the first byte of word 2.
    stim = {8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD};
    model(ok, n);
    pulse_start();
    send(6, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("after_reset");
    chk("after_reset_mem0_kept", 32'(mem[0]), 32'h12345);

    // Reload from address 0; header bits [15:11] must be ignored.
    stim = {8'hF8, 8'h02, 8'h03, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h07};
    add_csum();
    model(ok, n);
    chk("model_hdr_mask_ok", 32'(ok), 32'(1));
    pulse_start();
    send(stim.size(), 1'b0);
    finish_check("reload", ok, n);
    chk("reload_mem0", 32'(mem[0]), 32'h30FF0);
    chk("reload_mem1", 32'(mem[1]), 32'h00007);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Write-side companion to the CPU's instruction memory: accepts a byte stream over a valid/ready handshake, packs each three bytes into one 18-bit instruction, and writes the instructions into instruction memory at consecutive addresses starting from 0. Holds the CPU in reset while loading and releases it only after a complete, well-formed image has been written. Sits between a host byte source (UART receiver or testbench) and the instruction memory write port; the CPU's program-counter path keeps reading the same memory.

## Interface
- ADDR_W, 10, instruction memory address width
- WORD_W, 18, instruction width
- DEPTH, 1024, maximum number of words in an image
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load, honoured only in IDLE, DONE or ERROR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  WORD_W  write data
- cpu_reset  out  1  held high until a load completes successfully
- busy  out  1  high in HEADER, LOAD, WRITE, CHECK
- done  out  1  high in DONE
- error  out  1  high in ERROR
- word_count  out  ADDR_W+1  words written in the current load

## Operation
- States: IDLE, HEADER, LOAD, WRITE, CHECK, DONE, ERROR.
- IDLE: in_ready=0; start -> HEADER, clears word_count, byte counter, address and checksum.
- HEADER: accepts 2 bytes, big-endian length N; only bits [10:0] are used and bits [15:11] are ignored. After the second byte, N=0 or N>DEPTH -> ERROR, else -> LOAD.
- LOAD: accepts 3 bytes per word, big-endian. Byte 0 bits [1:0] map to word[17:16] and its bits [7:2] are ignored. Byte 1 maps to word[15:8], byte 2 to word[7:0]. The third byte -> WRITE.
- WRITE: imem_we=1, imem_addr = current address, imem_wdata = packed word; in_ready=0. Next cycle: address+1, word_count+1. If word_count reaches N -> CHECK (checksum enabled) or DONE, else -> LOAD.
- DONE: cpu_reset=0. start -> HEADER and reasserts cpu_reset in the same cycle the FSM leaves DONE.
- ERROR: cpu_reset=1, sticky until start or reset.
- start in HEADER, LOAD, WRITE or CHECK is ignored.
- A byte is transferred only when in_valid && in_ready. in_data is sampled on that edge. Stalls on in_valid=0 are unbounded, with no timeout.
- Address never wraps, because N≤DEPTH is enforced.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, busy 0, done 0, error 0, word_count 0.
- Registered outputs only; in_ready is a decode of registered state.
- Latency: imem_we is asserted in the cycle after the third byte of a word is accepted.
- Sustained throughput is 4 cycles per word (3 byte cycles plus 1 WRITE cycle).
- DONE is entered the cycle after the final WRITE (or after the checksum byte), and cpu_reset falls on that same edge.
- Reset mid-load: immediate return to reset values. Memory contents already written are left as they are, and cpu_reset stays 1.

## Configuration
- LOADER_CHECKSUM_EN defined: after the last word, the CHECK state accepts one byte. That byte must equal the XOR of every payload byte, header bytes excluded. A match goes to DONE; a mismatch goes to ERROR and no further writes occur.
- LOADER_CHECKSUM_EN undefined: the CHECK state is not built, and the last WRITE goes directly to DONE.

## Structure
- Shared package cpu_pkg: WORD_W, ADDR_W, DEPTH constants and the loader_state_t enum.
- Sub-module loader_byte_packer: 3-byte shift/assemble register with byte index counter and word_ready flag; the FSM owns address, count and checksum.

## Test plan
- Reset, then idle 10 cycles -> cpu_reset=1, in_ready=0, imem_we never asserted.
- start; bytes 00 02, 01 23 45, 02 AB CD (checksum byte 0x03 appended when enabled) -> writes addr 0 = 0x12345, addr 1 = 0x2ABCD, word_count=2, done=1, cpu_reset=0.
- Header 00 00 -> error=1 and no writes; header 04 01 (N=1025) -> error=1.
- LOADER_CHECKSUM_EN with one word 00 01, 00 00 01 and checksum byte 0x00 -> error=1, cpu_reset=1, one write of 0x00001 at addr 0.
- in_valid toggled every other cycle during a 3-word load -> identical memory contents; start pulsed mid-load is ignored.
- reset asserted after the first byte of word 2 -> all outputs at reset values next cycle; a new start and full image then loads correctly from addr 0.
